// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and default widths for the memory port arbiter
package mips_pkg;

  localparam int MIPS_AW = 32;
  localparam int MIPS_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_WAIT = 2'd1,
    ARB_D_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - wait-cycle counter with sticky timeout flag
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout_err
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] wdog;
  logic [7:0] wdog_inc;

  // Saturate so a memory that never answers cannot wrap the count.
  assign wdog_inc = (wdog == 8'hFF) ? wdog : wdog + 8'd1;

  // Count waiting cycles; the error flag is raised as the count reaches the limit and held until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog        <= 8'd0;
      timeout_err <= 1'b0;
    end else if (clear) begin
      wdog <= 8'd0;
    end else if (enable) begin
      wdog <= wdog_inc;
      if (wdog_inc == LIMIT) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of one variable-latency memory port
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int AW      = MIPS_AW,
  parameter int DW      = MIPS_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic          istall,
  output logic          ivalid,
  output logic [DW-1:0] irdata,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic          dstall,
  output logic          dvalid,
  output logic [DW-1:0] drdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          timeout_err
);

  arb_state_e state, state_next;
  logic       abort, abort_next;
  logic       issue_d, issue_i;
  logic       ready_seen;
  logic       i_deliver, d_deliver;

  // A response only counts while a request is actually outstanding.
  assign ready_seen = mem_req & mem_ready;

  // A fetch whose requester went away (branch redirect), now or earlier, completes silently.
  assign i_deliver = (state == ARB_I_WAIT) & ready_seen & ~abort & ireq;
  assign d_deliver = (state == ARB_D_WAIT) & ready_seen;

  // Stalls are combinational so the pipeline advances in the very cycle the valid pulse is high.
  assign istall = ireq & ~ivalid;
  assign dstall = dreq & ~dvalid;

  // State and abort registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      abort <= 1'b0;
    end else begin
      state <= state_next;
      abort <= abort_next;
    end
  end

  // Next-state logic: data accesses win over fetch when both are requested in IDLE.
  always_comb begin
    state_next = state;
    abort_next = abort;
    issue_d    = 1'b0;
    issue_i    = 1'b0;
    case (state)
      ARB_IDLE: begin
        abort_next = 1'b0;
        if (dreq) begin
          issue_d    = 1'b1;
          state_next = ARB_D_WAIT;
        end else if (ireq) begin
          issue_i    = 1'b1;
          state_next = ARB_I_WAIT;
        end
      end
      ARB_I_WAIT: begin
        if (!ireq) begin
          abort_next = 1'b1;
        end
        if (ready_seen) begin
          abort_next = 1'b0;
          state_next = ARB_IDLE;
        end
      end
      ARB_D_WAIT: begin
        if (ready_seen) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        abort_next = 1'b0;
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Registered memory interface: latched at issue, held stable while waiting, released on response.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue_d) begin
      mem_req   <= 1'b1;
      mem_we    <= dwe;
      mem_addr  <= daddr;
      mem_wdata <= dwdata;
    end else if (issue_i) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= iaddr;
    end else if (ready_seen) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Response capture: one-cycle valid pulses; stores leave drdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      irdata <= '0;
      drdata <= '0;
    end else begin
      ivalid <= i_deliver;
      dvalid <= d_deliver;
      if (i_deliver) begin
        irdata <= mem_rdata;
      end
      if (d_deliver && !mem_we) begin
        drdata <= mem_rdata;
      end
    end
  end

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      ((state == ARB_IDLE) | ready_seen),
    .enable     ((state != ARB_IDLE) & ~ready_seen),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe, mem_ready;
  logic [31:0] iaddr, daddr, dwdata, mem_rdata;
  logic        istall, ivalid, dstall, dvalid, mem_req, mem_we, timeout_err;
  logic [31:0] irdata, drdata, mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .istall(istall), .ivalid(ivalid), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dstall(dstall), .dvalid(dvalid), .drdata(drdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A load/store must stay requested until its dvalid cycle.
  logic dstall_q = 1'b0;
  logic reset_q  = 1'b1;
  always @(posedge clk) begin
    if (!reset && !reset_q && dstall_q && !dvalid && !dreq) begin
      fails++;
      $error("FAIL dreq_held: observed dreq 0 expected 1 while data access outstanding");
    end
    dstall_q <= dstall;
    reset_q  <= reset;
  end

  // Random-phase scoreboard state
  int          fl;
  int          lat;
  bit          rdy, issued;
  bit          i_act, d_act, d_we_b, fl_we;
  bit          exp_iv, exp_dv, exp_req;
  logic [31:0] i_a, d_a, d_wd, fl_addr, fl_wdata, fl_data, exp_ir, exp_dr;

  initial begin
    reset = 1'b1; ireq = 0; dreq = 0; dwe = 0; mem_ready = 0;
    iaddr = 0; daddr = 0; dwdata = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_valids", {30'd0, ivalid, dvalid}, 0);
    chk("rst_irdata", irdata, 0);
    chk("rst_drdata", drdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_timeout", {31'd0, timeout_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: fetch with immediate memory
    ireq = 1; iaddr = 32'h0040_0000; mem_ready = 1; mem_rdata = 32'h2008_0005;
    #1 chk("t1_istall_c0", {31'd0, istall}, 1);
    @(negedge clk);
    chk("t1_mem_req_c1", {31'd0, mem_req}, 1);
    chk("t1_mem_addr", mem_addr, 32'h0040_0000);
    chk("t1_mem_we", {31'd0, mem_we}, 0);
    chk("t1_istall_c1", {31'd0, istall}, 1);
    chk("t1_ivalid_c1", {31'd0, ivalid}, 0);
    @(negedge clk);
    chk("t1_ivalid_c2", {31'd0, ivalid}, 1);
    chk("t1_irdata", irdata, 32'h2008_0005);
    chk("t1_istall_c2", {31'd0, istall}, 0);
    chk("t1_mem_req_c2", {31'd0, mem_req}, 0);
    ireq = 0; mem_ready = 0;
    @(negedge clk);
    chk("t1_ivalid_c3", {31'd0, ivalid}, 0);

    // 2: simultaneous requests, data first
    ireq = 1; iaddr = 32'h0040_0004; dreq = 1; dwe = 0; daddr = 32'h1000_0010;
    @(negedge clk);
    chk("t2_first_addr", mem_addr, 32'h1000_0010);
    chk("t2_stalls", {30'd0, istall, dstall}, 32'd3);
    @(negedge clk);
    chk("t2_addr_hold", mem_addr, 32'h1000_0010);
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("t2_dvalid", {31'd0, dvalid}, 1);
    chk("t2_ivalid_not_yet", {31'd0, ivalid}, 0);
    chk("t2_drdata", drdata, 32'hCAFE_0001);
    chk("t2_dstall", {31'd0, dstall}, 0);
    dreq = 0; mem_ready = 0;
    @(negedge clk);
    chk("t2_second_req", {31'd0, mem_req}, 1);
    chk("t2_second_addr", mem_addr, 32'h0040_0004);
    repeat (2) @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h8C08_0000;
    @(negedge clk);
    chk("t2_ivalid", {31'd0, ivalid}, 1);
    chk("t2_irdata", irdata, 32'h8C08_0000);
    ireq = 0; mem_ready = 0;
    @(negedge clk);

    // 3: store
    dreq = 1; dwe = 1; daddr = 32'h1000_0000; dwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_we_c1", {31'd0, mem_we}, 1);
    chk("t3_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_addr", mem_addr, 32'h1000_0000);
    @(negedge clk);
    chk("t3_we_c2", {31'd0, mem_we}, 1);
    chk("t3_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("t3_dvalid", {31'd0, dvalid}, 1);
    chk("t3_drdata_kept", drdata, 32'hCAFE_0001);
    chk("t3_we_clear", {31'd0, mem_we}, 0);
    dreq = 0; dwe = 0; mem_ready = 0;
    @(negedge clk);
    chk("t3_dvalid_once", {31'd0, dvalid}, 0);

    // 4: fetch abort
    ireq = 1; iaddr = 32'h0040_0008;
    @(negedge clk);
    chk("t4_mem_req", {31'd0, mem_req}, 1);
    ireq = 0;
    @(negedge clk);
    chk("t4_ivalid_c2", {31'd0, ivalid}, 0);
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t4_no_ivalid", {31'd0, ivalid}, 0);
    chk("t4_irdata_kept", irdata, 32'h8C08_0000);
    chk("t4_mem_req_low", {31'd0, mem_req}, 0);
    ireq = 1; iaddr = 32'h0040_0020; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("t4_next_addr", mem_addr, 32'h0040_0020);
    @(negedge clk);
    chk("t4_next_ivalid", {31'd0, ivalid}, 1);
    chk("t4_next_irdata", irdata, 32'h1111_1111);
    ireq = 0; mem_ready = 0;
    @(negedge clk);

    // 5: watchdog with TIMEOUT=4
    dreq = 1; dwe = 0; daddr = 32'h1000_0020;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_no_err_c%0d", k), {31'd0, timeout_err}, 0);
    end
    @(negedge clk);
    chk("t5_err_set", {31'd0, timeout_err}, 1);
    chk("t5_still_waiting", {30'd0, mem_req, dstall}, 32'd3);
    mem_ready = 1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    chk("t5_dvalid", {31'd0, dvalid}, 1);
    chk("t5_drdata", drdata, 32'h0000_0077);
    chk("t5_err_sticky", {31'd0, timeout_err}, 1);
    dreq = 0; mem_ready = 0;
    @(negedge clk);
    chk("t5_err_sticky2", {31'd0, timeout_err}, 1);
    reset = 1;
    @(negedge clk);
    chk("t5_err_reset", {31'd0, timeout_err}, 0);
    chk("t5_drdata_reset", drdata, 0);
    reset = 0;
    @(negedge clk);

    // 6: reset mid-transaction
    ireq = 1; iaddr = 32'h0040_0030;
    @(negedge clk);
    chk("t6_mem_req", {31'd0, mem_req}, 1);
    reset = 1; mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("t6_mem_req_rst", {31'd0, mem_req}, 0);
    chk("t6_istall", {31'd0, istall}, 1);
    chk("t6_ivalid_rst", {31'd0, ivalid}, 0);
    reset = 0; ireq = 0;
    @(negedge clk);
    chk("t6_stale_ivalid", {31'd0, ivalid}, 0);
    chk("t6_irdata", irdata, 0);
    ireq = 1; iaddr = 32'h0040_0034; mem_rdata = 32'h0102_0304;
    @(negedge clk);
    chk("t6_idle_issue", mem_addr, 32'h0040_0034);
    @(negedge clk);
    chk("t6_ivalid", {31'd0, ivalid}, 1);
    chk("t6_irdata2", irdata, 32'h0102_0304);
    ireq = 0; mem_ready = 0;
    @(negedge clk);

    // Random traffic against a transaction-level scoreboard; the bench is both requester and memory.
    fl = 0; rdy = 0; lat = 0; i_act = 0; d_act = 0; d_we_b = 0;
    i_a = 0; d_a = 0; d_wd = 0; fl_addr = 0; fl_wdata = 0; fl_we = 0; fl_data = 0;
    exp_ir = 32'h0102_0304; exp_dr = 32'h0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      exp_iv = 0; exp_dv = 0; issued = 0;
      if (fl != 0 && rdy) begin
        if (fl == 2) begin
          exp_dv = 1;
          if (!fl_we) exp_dr = fl_data;
        end else begin
          exp_iv = 1;
          exp_ir = fl_data;
        end
        fl = 0;
      end else if (fl == 0) begin
        if (d_act) begin
          fl = 2; fl_addr = d_a; fl_we = d_we_b; fl_wdata = d_wd; issued = 1;
        end else if (i_act) begin
          fl = 1; fl_addr = i_a; fl_we = 0; issued = 1;
        end
        if (issued) lat = $urandom_range(0, 3);
      end
      exp_req = (fl != 0);
      chk("rnd_mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (fl != 0) begin
        chk("rnd_mem_addr", mem_addr, fl_addr);
        chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, fl_we});
        if (fl_we) chk("rnd_mem_wdata", mem_wdata, fl_wdata);
      end
      chk("rnd_ivalid", {31'd0, ivalid}, {31'd0, exp_iv});
      chk("rnd_dvalid", {31'd0, dvalid}, {31'd0, exp_dv});
      chk("rnd_irdata", irdata, exp_ir);
      chk("rnd_drdata", drdata, exp_dr);
      chk("rnd_istall", {31'd0, istall}, {31'd0, i_act & ~exp_iv});
      chk("rnd_dstall", {31'd0, dstall}, {31'd0, d_act & ~exp_dv});

      if (exp_dv) d_act = 0;
      if (exp_iv) i_act = 0;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_we_b = 1'($urandom_range(0, 1));
        d_a = $urandom(); d_wd = $urandom();
      end
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1; i_a = $urandom() & 32'hFFFF_FFFC;
      end
      dreq = d_act; dwe = d_we_b; daddr = d_a; dwdata = d_wd;
      ireq = i_act; iaddr = i_a;

      if (fl != 0) begin
        rdy = (lat == 0);
        if (lat > 0) lat--;
        fl_data = $urandom();
        mem_rdata = fl_data;
      end else begin
        rdy = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom();
      end
      mem_ready = rdy;
    end
    @(negedge clk);
    chk("rnd_no_timeout", {31'd0, timeout_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
